// File: rtl/scrambler_pkg.sv
// rtl/scrambler_pkg.sv - shared constants, types and helpers for the symbol scrambler
package scrambler_pkg;

  // Symbol width carried on the stream
  localparam int SYM_W = 2;

  // Gold-sequence register length and seeds (x = 1, y = all ones)
  localparam int LFSR_W = 18;
  localparam logic [LFSR_W-1:0] X_SEED = 18'h00001;
  localparam logic [LFSR_W-1:0] Y_SEED = 18'h3FFFF;

  // Feedback taps: x(i+18) = x(i+7) ^ x(i), y(i+18) = y(i+10) ^ y(i+7) ^ y(i+5) ^ y(i)
  localparam logic [LFSR_W-1:0] X_FB_MASK = 18'h00081;
  localparam logic [LFSR_W-1:0] Y_FB_MASK = 18'h004A1;

  // Tap sets that yield the sequence bit 131072 positions ahead without a second register pair
  localparam logic [LFSR_W-1:0] X_OFS_MASK = 18'h08050;
  localparam logic [LFSR_W-1:0] Y_OFS_MASK = 18'h0FF60;

  typedef logic [SYM_W-1:0] sym_t;

  // Contents of the single output pipeline stage
  typedef struct packed {
    sym_t data;
    logic sof;
    logic eof;
  } out_word_t;

  // Modulo-4 add or subtract; wraps naturally by truncation to SYM_W bits
  function automatic sym_t mod4_add(input sym_t a, input sym_t b, input logic sub);
    sym_t res;
    if (sub) begin
      res = a - b;
    end else begin
      res = a + b;
    end
    return res;
  endfunction

endpackage

// File: rtl/randomizer.sv
// rtl/randomizer.sv - Gold-sequence pseudo-randomizer producing one 2-bit value per step
module randomizer
  import scrambler_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  output logic [SYM_W-1:0] o_r
);

  // Bit k of each register holds sequence element (i + k); bit 0 is the current element
  logic [LFSR_W-1:0] x_q;
  logic [LFSR_W-1:0] y_q;

  // Step both m-sequences on enable; reset reloads the seeds and overrides enable
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      x_q <= X_SEED;
      y_q <= Y_SEED;
    end else if (i_en) begin
      x_q <= {^(x_q & X_FB_MASK), x_q[LFSR_W-1:1]};
      y_q <= {^(y_q & Y_FB_MASK), y_q[LFSR_W-1:1]};
    end
  end

  // Low bit is z(i); high bit is z(i + 131072) formed from the offset tap sets
  always_comb begin
    o_r    = '0;
    o_r[0] = x_q[0] ^ y_q[0];
    o_r[1] = (^(x_q & X_OFS_MASK)) ^ (^(y_q & Y_OFS_MASK));
  end

endmodule

// File: rtl/symbol_scrambler.sv
// rtl/symbol_scrambler.sv - adds (or removes) a framed randomizer sequence on a 2-bit symbol stream
module symbol_scrambler
  import scrambler_pkg::*;
#(
  parameter int FRAME_SYMBOLS = 64,
  parameter bit DESCRAMBLE    = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [SYM_W-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [SYM_W-1:0] o_data,
  output logic             o_valid,
  output logic             o_sof,
  output logic             o_eof,
  input  logic             i_ready
);

  localparam int CNT_W = (FRAME_SYMBOLS > 2) ? $clog2(FRAME_SYMBOLS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_SYMBOLS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] sym_cnt;
  logic             acc;
  logic             last;
  logic             rnd_reset;
  logic             rnd_en;
  sym_t             rnd_r;
  out_word_t        out_q;
  logic             valid_q;

  // Single pipeline stage: room exists when empty or when the held symbol leaves this cycle
  assign o_ready = !valid_q || i_ready;
  assign acc     = i_valid && o_ready;
  assign last    = (sym_cnt == LAST_IDX);

  // Frame end restarts the sequence instead of stepping it, so each frame begins at index 0
  assign rnd_reset = i_reset || (acc && last);
  assign rnd_en    = acc && !last && !i_reset;

  randomizer u_randomizer (
    .i_clk   (i_clk),
    .i_reset (rnd_reset),
    .i_en    (rnd_en),
    .o_r     (rnd_r)
  );

  // Position of the next accepted symbol within its frame
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sym_cnt <= '0;
    end else if (acc) begin
      if (last) begin
        sym_cnt <= '0;
      end else begin
        sym_cnt <= sym_cnt + CNT_ONE;
      end
    end
  end

  // Output register: load on accept, clear valid on drain, hold everything while stalled
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else if (acc) begin
      out_q.data <= mod4_add(i_data, rnd_r, DESCRAMBLE);
      out_q.sof  <= (sym_cnt == '0);
      out_q.eof  <= last;
      valid_q    <= 1'b1;
    end else if (valid_q && i_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign o_data  = out_q.data;
  assign o_sof   = out_q.sof;
  assign o_eof   = out_q.eof;
  assign o_valid = valid_q;

endmodule
